id_ex_hazard_stage: RTL and testbench
=====================================

Name: id_ex_hazard_stage

Overview:
ID/EX pipeline register for the 5-stage MIPS core, with integrated load-use hazard detection. It captures decoder control and operand data from the decode stage each cycle and presents them to the execute stage. It detects load-use hazards against the instruction already in EX, requests an upstream stall, and injects a bubble. It also honours a flush from branch/jump resolution and a global hold, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
NBits, 32, datapath width (operands, extends, PC)
RegBits, 5, register-index width
CntBits, 16, stall-counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
in_Hold  input  1  global freeze; all state holds
in_Flush  input  1  squash instruction entering EX (branch/jump taken)
id_Valid  input  1  ID holds a real instruction
id_Rs  input  RegBits  Instruction[25:21]
id_Rt  input  RegBits  Instruction[20:16]
id_WriteRegister  input  RegBits  destination after RegDst mux
id_Ctrl  input  16  {BranchNE,BranchEQ,ALUOp[2:0],ALUSrc,RegWrite,MemWrite,MemRead,MemtoReg,ShamtSelector,RegisterOrPC,ALUMemOrPC,JumpControl,2'b00}
id_ReadData1, id_ReadData2, id_InmmediateExtend, id_ShamtExtend, id_PCPlus4  input  NBits each  decode-stage data
ex_Valid  output  1  EX holds a real instruction
ex_Ctrl  output  16  registered control bundle, same packing
ex_Rs, ex_Rt, ex_WriteRegister  output  RegBits  registered indices
ex_ReadData1, ex_ReadData2, ex_InmmediateExtend, ex_ShamtExtend, ex_PCPlus4  output  NBits  registered data
Stall  output  1  hold PC and IF/ID this cycle (combinational)
StallCount  output  CntBits  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset==0 at rising edge): every ex_* output = 0, ex_Valid = 0, StallCount = 0. Reset overrides hold, flush and hazard.
- Hazard (combinational): hazard = ex_Valid & ex_Ctrl.MemRead & (ex_WriteRegister != 0) & id_Valid & ((ex_WriteRegister == id_Rs) | (ex_WriteRegister == id_Rt)).
  - rt is compared conservatively for every instruction.
  - Register 0 never causes a hazard.
- Stall = hazard & ~in_Flush. Stall is independent of in_Hold.
- Per-edge priority when reset==1:
  1. in_Hold=1: all registers keep their values; StallCount does not change.
  2. in_Flush=1: bubble — ex_Valid=0, ex_Ctrl=0; data/index registers load ID values (don't-care).
  3. hazard=1: bubble as in (2); StallCount += 1, saturating at all-ones.
  4. Otherwise: all ex_* registers load their id_* counterparts; ex_Valid = id_Valid; ex_Ctrl = id_Valid ? id_Ctrl : 0.
- Latency: 1 cycle ID→EX. A load-use pair costs exactly 1 bubble. The second compare after the bubble fails because ex_Valid=0.
- Back-to-back loads with a dependence chain stall once per dependent pair.
- Flush and hazard in the same cycle: flush wins, Stall=0, StallCount unchanged.
- Hold and hazard in the same cycle: Stall=1, registers frozen, no count.
- No other state. Outputs are purely registered except Stall.

Test Plan:
- Reset: drive reset=0 for 2 cycles with nonzero inputs → all ex_* = 0, ex_Valid=0, StallCount=0, Stall=0.
- Pass-through: id_Valid=1, id_ReadData1=0x0000_1234, id_Ctrl with RegWrite=1, id_WriteRegister=8 → next edge ex_ReadData1=0x0000_1234, ex_WriteRegister=8, ex_Valid=1, Stall=0.
- Load-use: lw $9 in EX (MemRead=1, ex_WriteRegister=9); ID has add with id_Rs=9 → Stall=1; next edge ex_Valid=0, ex_Ctrl=0, StallCount=1; following edge the add enters EX with Stall=0.
- $zero write: EX lw to reg 0, id_Rs=0 → Stall=0, no bubble.
- Flush plus hazard together: same setup as load-use with in_Flush=1 → Stall=0, bubble inserted, StallCount stays 0.
- Hold: in_Hold=1 for 3 cycles with changing id_* inputs → ex_* unchanged. Release hold → next edge loads the current id_* values. Also force StallCount to 0xFFFF → further hazards keep it at 0xFFFF.

Source files
------------

// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection,
// bubble injection, flush/hold handling and a stall counter.
module id_ex_hazard_stage #(
    parameter int NBits   = 32,
    parameter int RegBits = 5,
    parameter int CntBits = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_Hold,
    input  logic               in_Flush,
    input  logic               id_Valid,
    input  logic [RegBits-1:0] id_Rs,
    input  logic [RegBits-1:0] id_Rt,
    input  logic [RegBits-1:0] id_WriteRegister,
    input  logic [15:0]        id_Ctrl,
    input  logic [NBits-1:0]   id_ReadData1,
    input  logic [NBits-1:0]   id_ReadData2,
    input  logic [NBits-1:0]   id_InmmediateExtend,
    input  logic [NBits-1:0]   id_ShamtExtend,
    input  logic [NBits-1:0]   id_PCPlus4,
    output logic               ex_Valid,
    output logic [15:0]        ex_Ctrl,
    output logic [RegBits-1:0] ex_Rs,
    output logic [RegBits-1:0] ex_Rt,
    output logic [RegBits-1:0] ex_WriteRegister,
    output logic [NBits-1:0]   ex_ReadData1,
    output logic [NBits-1:0]   ex_ReadData2,
    output logic [NBits-1:0]   ex_InmmediateExtend,
    output logic [NBits-1:0]   ex_ShamtExtend,
    output logic [NBits-1:0]   ex_PCPlus4,
    output logic               Stall,
    output logic [CntBits-1:0] StallCount
);

    localparam int MemReadBit = 7;

    typedef struct packed {
        logic               valid;
        logic [15:0]        ctrl;
        logic [RegBits-1:0] rs;
        logic [RegBits-1:0] rt;
        logic [RegBits-1:0] wr;
        logic [NBits-1:0]   rd1;
        logic [NBits-1:0]   rd2;
        logic [NBits-1:0]   imm;
        logic [NBits-1:0]   shamt;
        logic [NBits-1:0]   pc4;
    } ex_t;

    ex_t               ex_q, ex_d;
    logic [CntBits-1:0] cnt_q, cnt_d;
    logic              hazard;

    always_comb begin
        hazard = ex_q.valid
               & ex_q.ctrl[MemReadBit]
               & (ex_q.wr != '0)
               & id_Valid
               & ((ex_q.wr == id_Rs) | (ex_q.wr == id_Rt));
    end

    assign Stall = hazard & ~in_Flush;

    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!in_Hold) begin
            ex_d.rs    = id_Rs;
            ex_d.rt    = id_Rt;
            ex_d.wr    = id_WriteRegister;
            ex_d.rd1   = id_ReadData1;
            ex_d.rd2   = id_ReadData2;
            ex_d.imm   = id_InmmediateExtend;
            ex_d.shamt = id_ShamtExtend;
            ex_d.pc4   = id_PCPlus4;
            if (in_Flush) begin
                ex_d.valid = 1'b0;
                ex_d.ctrl  = '0;
            end else if (hazard) begin
                ex_d.valid = 1'b0;
                ex_d.ctrl  = '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ex_d.valid = id_Valid;
                ex_d.ctrl  = id_Valid ? id_Ctrl : 16'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign ex_Valid            = ex_q.valid;
    assign ex_Ctrl             = ex_q.ctrl;
    assign ex_Rs               = ex_q.rs;
    assign ex_Rt               = ex_q.rt;
    assign ex_WriteRegister    = ex_q.wr;
    assign ex_ReadData1        = ex_q.rd1;
    assign ex_ReadData2        = ex_q.rd2;
    assign ex_InmmediateExtend = ex_q.imm;
    assign ex_ShamtExtend      = ex_q.shamt;
    assign ex_PCPlus4          = ex_q.pc4;
    assign StallCount          = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// Directed bench for id_ex_hazard_stage with a transaction-level
// reference model checked every cycle plus literal spot checks.
module tb_id_ex_hazard_stage;

    localparam logic [15:0] CTRL_LW  = 16'h06C0;
    localparam logic [15:0] CTRL_ADD = 16'h1200;
    localparam logic [15:0] CTRL_RW  = 16'h0200;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_Hold, in_Flush, id_Valid;
    logic [4:0]  id_Rs, id_Rt, id_WriteRegister;
    logic [15:0] id_Ctrl;
    logic [31:0] id_ReadData1, id_ReadData2, id_InmmediateExtend;
    logic [31:0] id_ShamtExtend, id_PCPlus4;

    logic        ex_Valid;
    logic [15:0] ex_Ctrl;
    logic [4:0]  ex_Rs, ex_Rt, ex_WriteRegister;
    logic [31:0] ex_ReadData1, ex_ReadData2, ex_InmmediateExtend;
    logic [31:0] ex_ShamtExtend, ex_PCPlus4;
    logic        Stall;
    logic [15:0] StallCount;

    logic        s_Valid;
    logic [15:0] s_Ctrl;
    logic [4:0]  s_Rs, s_Rt, s_WriteRegister;
    logic [31:0] s_ReadData1, s_ReadData2, s_Imm, s_Shamt, s_PCPlus4;
    logic        s_Stall;
    logic [1:0]  s_StallCount;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    id_ex_hazard_stage dut (
        .clk(clk), .reset(reset), .in_Hold(in_Hold), .in_Flush(in_Flush),
        .id_Valid(id_Valid), .id_Rs(id_Rs), .id_Rt(id_Rt),
        .id_WriteRegister(id_WriteRegister), .id_Ctrl(id_Ctrl),
        .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
        .id_InmmediateExtend(id_InmmediateExtend),
        .id_ShamtExtend(id_ShamtExtend), .id_PCPlus4(id_PCPlus4),
        .ex_Valid(ex_Valid), .ex_Ctrl(ex_Ctrl), .ex_Rs(ex_Rs),
        .ex_Rt(ex_Rt), .ex_WriteRegister(ex_WriteRegister),
        .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2),
        .ex_InmmediateExtend(ex_InmmediateExtend),
        .ex_ShamtExtend(ex_ShamtExtend), .ex_PCPlus4(ex_PCPlus4),
        .Stall(Stall), .StallCount(StallCount)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    id_ex_hazard_stage #(.CntBits(2)) dut_s (
        .clk(clk), .reset(reset), .in_Hold(in_Hold), .in_Flush(in_Flush),
        .id_Valid(id_Valid), .id_Rs(id_Rs), .id_Rt(id_Rt),
        .id_WriteRegister(id_WriteRegister), .id_Ctrl(id_Ctrl),
        .id_ReadData1(id_ReadData1), .id_ReadData2(id_ReadData2),
        .id_InmmediateExtend(id_InmmediateExtend),
        .id_ShamtExtend(id_ShamtExtend), .id_PCPlus4(id_PCPlus4),
        .ex_Valid(s_Valid), .ex_Ctrl(s_Ctrl), .ex_Rs(s_Rs),
        .ex_Rt(s_Rt), .ex_WriteRegister(s_WriteRegister),
        .ex_ReadData1(s_ReadData1), .ex_ReadData2(s_ReadData2),
        .ex_InmmediateExtend(s_Imm),
        .ex_ShamtExtend(s_Shamt), .ex_PCPlus4(s_PCPlus4),
        .Stall(s_Stall), .StallCount(s_StallCount)
    );

    // Model: what instruction sits in EX, and how many hazards occurred.
    bit          m_real;
    logic [15:0] m_ctrl;
    logic [4:0]  m_rs, m_rt, m_dest;
    logic [31:0] m_d1, m_d2, m_imm, m_sh, m_pc;
    int          m_hazards;

    function automatic bit m_load_use();
        bit is_load;
        bit uses;
        is_load = m_real && m_ctrl[7] && (m_dest != 5'd0);
        uses    = (m_dest == id_Rs) || (m_dest == id_Rt);
        return is_load && id_Valid && uses;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_real = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_dest = 0;
            m_d1 = 0; m_d2 = 0; m_imm = 0; m_sh = 0; m_pc = 0;
            m_hazards = 0;
        end else if (!in_Hold) begin
            if (!in_Flush && m_load_use()) begin
                m_hazards = m_hazards + 1;
                m_real = 0;
            end else if (in_Flush) begin
                m_real = 0;
            end else begin
                m_real = id_Valid;
            end
            m_ctrl = m_real ? id_Ctrl : 16'h0;
            m_rs = id_Rs; m_rt = id_Rt; m_dest = id_WriteRegister;
            m_d1 = id_ReadData1; m_d2 = id_ReadData2;
            m_imm = id_InmmediateExtend; m_sh = id_ShamtExtend;
            m_pc = id_PCPlus4;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", {31'd0, ex_Valid}, {31'd0, m_real});
            chk("m_ctrl", {16'd0, ex_Ctrl}, {16'd0, m_ctrl});
            chk("m_stall", {31'd0, Stall},
                {31'd0, m_load_use() && !in_Flush});
            chk("m_cnt", {16'd0, StallCount}, sat(m_hazards, 65535));
            chk("m_cnt_sat", {30'd0, s_StallCount}, sat(m_hazards, 3));
            chk("m_s_stall", {31'd0, s_Stall}, {31'd0, Stall});
            if (m_real) begin
                chk("m_rs", {27'd0, ex_Rs}, {27'd0, m_rs});
                chk("m_rt", {27'd0, ex_Rt}, {27'd0, m_rt});
                chk("m_wr", {27'd0, ex_WriteRegister}, {27'd0, m_dest});
                chk("m_rd1", ex_ReadData1, m_d1);
                chk("m_rd2", ex_ReadData2, m_d2);
                chk("m_imm", ex_InmmediateExtend, m_imm);
                chk("m_sh", ex_ShamtExtend, m_sh);
                chk("m_pc", ex_PCPlus4, m_pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic v, input logic [15:0] c,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] wr, input logic [31:0] d);
        id_Valid = v; id_Ctrl = c;
        id_Rs = rs; id_Rt = rt; id_WriteRegister = wr;
        id_ReadData1 = d;
        id_ReadData2 = d ^ 32'hFFFF_0000;
        id_InmmediateExtend = d + 32'd1;
        id_ShamtExtend = {27'd0, d[4:0]};
        id_PCPlus4 = d + 32'd4;
    endtask

    initial begin
        reset = 1'b0; in_Hold = 1'b0; in_Flush = 1'b0;
        drv(1'b1, CTRL_LW, 5'd9, 5'd9, 5'd9, 32'hDEAD_BEEF);
        tick(); tick();
        chk("rst_valid", {31'd0, ex_Valid}, 32'd0);
        chk("rst_ctrl", {16'd0, ex_Ctrl}, 32'd0);
        chk("rst_rd1", ex_ReadData1, 32'd0);
        chk("rst_pc", ex_PCPlus4, 32'd0);
        chk("rst_wr", {27'd0, ex_WriteRegister}, 32'd0);
        chk("rst_cnt", {16'd0, StallCount}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);

        reset = 1'b1;
        chk_en = 1;
        drv(1'b1, CTRL_RW, 5'd1, 5'd2, 5'd8, 32'h0000_1234);
        tick();
        chk("pt_rd1", ex_ReadData1, 32'h0000_1234);
        chk("pt_wr", {27'd0, ex_WriteRegister}, 32'd8);
        chk("pt_valid", {31'd0, ex_Valid}, 32'd1);
        chk("pt_stall", {31'd0, Stall}, 32'd0);

        drv(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd9, 32'h0000_5000);
        tick();
        drv(1'b1, CTRL_ADD, 5'd9, 5'd3, 5'd10, 32'h0000_AAAA);
        #1 chk("lu_stall", {31'd0, Stall}, 32'd1);
        tick();
        chk("lu_bub_valid", {31'd0, ex_Valid}, 32'd0);
        chk("lu_bub_ctrl", {16'd0, ex_Ctrl}, 32'd0);
        chk("lu_cnt", {16'd0, StallCount}, 32'd1);
        chk("lu_stall2", {31'd0, Stall}, 32'd0);
        tick();
        chk("lu_add_valid", {31'd0, ex_Valid}, 32'd1);
        chk("lu_add_ctrl", {16'd0, ex_Ctrl}, {16'd0, CTRL_ADD});
        chk("lu_add_rd1", ex_ReadData1, 32'h0000_AAAA);

        drv(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd0, 32'h0000_6000);
        tick();
        drv(1'b1, CTRL_ADD, 5'd0, 5'd0, 5'd11, 32'h0000_6100);
        #1 chk("z_stall", {31'd0, Stall}, 32'd0);
        tick();
        chk("z_valid", {31'd0, ex_Valid}, 32'd1);
        chk("z_cnt", {16'd0, StallCount}, 32'd1);

        drv(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd9, 32'h0000_7000);
        tick();
        drv(1'b1, CTRL_ADD, 5'd9, 5'd3, 5'd12, 32'h0000_7100);
        in_Flush = 1'b1;
        #1 chk("fh_stall", {31'd0, Stall}, 32'd0);
        tick();
        in_Flush = 1'b0;
        chk("fh_valid", {31'd0, ex_Valid}, 32'd0);
        chk("fh_cnt", {16'd0, StallCount}, 32'd1);

        drv(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd9, 32'h0000_8000);
        tick();
        drv(1'b1, CTRL_LW, 5'd4, 5'd9, 5'd10, 32'h0000_8100);
        #1 chk("rt_stall", {31'd0, Stall}, 32'd1);
        tick(); tick();
        drv(1'b1, CTRL_ADD, 5'd10, 5'd3, 5'd13, 32'h0000_8200);
        #1 chk("chain_stall", {31'd0, Stall}, 32'd1);
        tick(); tick();
        chk("chain_cnt", {16'd0, StallCount}, 32'd3);

        drv(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd9, 32'h0000_9000);
        tick();
        in_Hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, CTRL_ADD, 5'd9, 5'd3, 5'd14, 32'h0000_9100 + i);
            #1 chk("hold_stall", {31'd0, Stall}, 32'd1);
            tick();
            chk("hold_rd1", ex_ReadData1, 32'h0000_9000);
            chk("hold_wr", {27'd0, ex_WriteRegister}, 32'd9);
            chk("hold_cnt", {16'd0, StallCount}, 32'd3);
        end
        drv(1'b1, CTRL_ADD, 5'd5, 5'd6, 5'd15, 32'h0000_9999);
        in_Hold = 1'b0;
        tick();
        chk("rel_rd1", ex_ReadData1, 32'h0000_9999);
        chk("rel_wr", {27'd0, ex_WriteRegister}, 32'd15);

        for (int i = 0; i < 5; i++) begin
            drv(1'b1, CTRL_LW, 5'd1, 5'd2, 5'd9, 32'h0000_A000 + i);
            tick();
            drv(1'b1, CTRL_ADD, 5'd3, 5'd9, 5'd16, 32'h0000_B000 + i);
            tick();
        end
        chk("sat_cnt", {16'd0, StallCount}, 32'd8);
        chk("sat_small", {30'd0, s_StallCount}, 32'd3);

        drv(1'b0, 16'h0, 5'd0, 5'd0, 5'd0, 32'd0);
        tick(); tick();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
